// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Buffered UART transmitter. A small FIFO accepts parallel words over a
//   valid/ready handshake. The frame FSM pops each word and shifts it out
//   LSB first as: start bit, data bits, optional parity, then 1 or 2 stop
//   bits. When the FIFO still holds a word at the end of a frame, the next
//   frame follows with no idle cycle between them.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst            synchronous active-high reset
//   i_p_data         word to transmit
//   i_data_valid     producer offers i_p_data
//   o_ready          FIFO not full; a word is pushed when valid & ready
//   i_parity_enable  1 = insert parity bit, sampled when the word is popped
//   i_parity_type    0 = even, 1 = odd, sampled when the word is popped
//   o_serial_data    serial line, idle high
//   o_busy           frame in progress
//   o_fifo_count     words currently buffered
//   o_frame_done     high during the last cycle of the final stop bit
//
// state  | meaning
// IDLE   | line high, waiting for a buffered word
// START  | start bit (line low)
// DATA   | DATA_WIDTH data bits, LSB first
// PARITY | one parity bit
// STOP   | STOP_BITS stop bits (line high)

module uart_tx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [DATA_WIDTH-1:0]         i_p_data,
  input  logic                          i_data_valid,
  output logic                          o_ready,
  input  logic                          i_parity_enable,
  input  logic                          i_parity_type,
  output logic                          o_serial_data,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_frame_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH);

  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);
  // Index of the final stop bit: 0 for one stop bit, 1 for two.
  localparam logic          S_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and pointers
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_d;
  logic                  ready_q;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  // Frame FSM
  state_t                state, state_d;
  logic [TW-1:0]         tmr, tmr_d;
  logic [BW-1:0]         bidx, bidx_d;
  logic                  sidx, sidx_d;
  logic [DATA_WIDTH-1:0] shreg, shreg_d;
  logic                  par_en, par_en_d;
  logic                  par_bit, par_bit_d;
  logic                  line, line_d;
  logic                  busy_d;
  logic                  busy_q;
  logic                  done_d;
  logic                  done_q;
  logic                  tick;

  // ready is a registered copy of (count != FULL), so a push is judged
  // against the count at the start of the cycle. A pop on the same edge
  // cannot free space for that push.
  assign push = i_data_valid & ready_q;
  assign head = mem[rd_ptr];

  always_comb begin
    count_d = count;
    case ({push, pop})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: count_d = count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_p_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count   <= count_d;
      ready_q <= (count_d != FULL);
    end
  end

  assign tick = (tmr == T_LAST);

  always_comb begin
    state_d   = state;
    tmr_d     = tick ? '0 : tmr + TW'(1);
    bidx_d    = bidx;
    sidx_d    = sidx;
    shreg_d   = shreg;
    par_en_d  = par_en;
    par_bit_d = par_bit;
    line_d    = line;
    pop       = 1'b0;

    case (state)
      S_IDLE: begin
        tmr_d = '0;
        if (count != '0) begin
          pop     = 1'b1;
          state_d = S_START;
          line_d  = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bidx_d  = '0;
          line_d  = shreg[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bidx == B_LAST) begin
            if (par_en) begin
              state_d = S_PARITY;
              line_d  = par_bit;
            end else begin
              state_d = S_STOP;
              sidx_d  = 1'b0;
              line_d  = 1'b1;
            end
          end else begin
            bidx_d  = bidx + BW'(1);
            shreg_d = shreg >> 1;
            line_d  = shreg[1];
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          sidx_d  = 1'b0;
          line_d  = 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (sidx == S_LAST) begin
            if (count != '0) begin
              pop     = 1'b1;
              state_d = S_START;
              line_d  = 1'b0;
            end else begin
              state_d = S_IDLE;
              line_d  = 1'b1;
            end
          end else begin
            sidx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
        line_d  = 1'b1;
      end
    endcase

    // Frame settings are captured with the word so that mid-frame changes
    // on the parity inputs cannot corrupt a frame already in flight.
    if (pop) begin
      shreg_d   = head;
      par_en_d  = i_parity_enable;
      par_bit_d = (^head) ^ i_parity_type;
    end
  end

  // Outputs are registered from the next-state values so they change on the
  // same edge as the state they describe.
  assign busy_d = (state_d != S_IDLE);
  assign done_d = (state_d == S_STOP) && (sidx_d == S_LAST) && (tmr_d == T_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      tmr     <= '0;
      bidx    <= '0;
      sidx    <= 1'b0;
      shreg   <= '0;
      par_en  <= 1'b0;
      par_bit <= 1'b0;
      line    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      tmr     <= tmr_d;
      bidx    <= bidx_d;
      sidx    <= sidx_d;
      shreg   <= shreg_d;
      par_en  <= par_en_d;
      par_bit <= par_bit_d;
      line    <= line_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_ready       = ready_q;
  assign o_fifo_count  = count;
  assign o_serial_data = line;
  assign o_busy        = busy_q;
  assign o_frame_done  = done_q;

endmodule
